// File: rtl/cfg_shift_regs_if.sv
// Bus between the upstream configuration FSM and cfg_shift_regs.
// Serial frame controls go in; committed configuration words and status flags come out.
interface cfg_shift_regs_if #(
  parameter int SIZESRSTAT  = 88,
  parameter int SIZESRDYN   = 16,
  parameter int SIZEADDRMUX = 7
);
  logic                   sel_dyn;
  logic                   sel_stat;
  logic                   en_fin;
  logic                   signal_in;
  logic                   err_clr;
  logic [SIZESRDYN-1:0]   dyn_cfg;
  logic [SIZESRSTAT-1:0]  stat_cfg;
  logic [SIZEADDRMUX-1:0] addr_mux;
  logic                   dyn_upd;
  logic                   stat_upd;
  logic                   err_len;
  logic                   err_sel;
  logic                   busy;

  modport master (
    output sel_dyn, sel_stat, en_fin, signal_in, err_clr,
    input  dyn_cfg, stat_cfg, addr_mux, dyn_upd, stat_upd, err_len, err_sel, busy
  );

  modport slave (
    input  sel_dyn, sel_stat, en_fin, signal_in, err_clr,
    output dyn_cfg, stat_cfg, addr_mux, dyn_upd, stat_upd, err_len, err_sel, busy
  );
endinterface

// File: rtl/cfg_shift_regs.sv
// Serial loader for a dynamic and a static configuration shift register.
// Frames are shifted MSB first and committed only when the bit count matches exactly.
module cfg_shift_regs #(
  parameter int SIZESRSTAT  = 88,
  parameter int SIZESRDYN   = 16,
  parameter int SIZEADDRMUX = 7
) (
  input  logic              CLK,
  input  logic              RST_N,
  cfg_shift_regs_if.slave   bus
);

  localparam int CW = $clog2(SIZESRSTAT + 2);

  typedef enum logic [1:0] {IDLE, SH_DYN, SH_STAT} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SIZESRDYN-1:0]    sr_dyn_q, sr_dyn_d;
  logic [SIZESRSTAT-1:0]   sr_stat_q, sr_stat_d;
  logic [SIZESRDYN-1:0]    dyn_cfg_q, dyn_cfg_d;
  logic [SIZESRSTAT-1:0]   stat_cfg_q, stat_cfg_d;
  logic                    dyn_upd_q, dyn_upd_d;
  logic                    stat_upd_q, stat_upd_d;
  logic                    err_len_q, err_len_d;
  logic                    err_sel_q, err_sel_d;
  logic                    busy_q, busy_d;

  logic                    conflict, dyn_go, stat_go, enter_idle;
  logic [CW-1:0]           cnt_lim, cnt_inc;

  assign conflict = bus.sel_dyn & bus.sel_stat;
  assign dyn_go   = bus.sel_dyn & ~bus.en_fin & ~bus.sel_stat;
  assign stat_go  = bus.sel_stat & ~bus.sel_dyn;

  // Count stops one past the register size so over-length frames stay detectable.
  assign cnt_lim = (state_q == SH_DYN) ? CW'(SIZESRDYN + 1) : CW'(SIZESRSTAT + 1);
  assign cnt_inc = (cnt_q >= cnt_lim) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_dyn_d   = sr_dyn_q;
    sr_stat_d  = sr_stat_q;
    dyn_cfg_d  = dyn_cfg_q;
    stat_cfg_d = stat_cfg_q;
    dyn_upd_d  = 1'b0;
    stat_upd_d = 1'b0;
    err_len_d  = err_len_q & ~bus.err_clr;
    err_sel_d  = err_sel_q & ~bus.err_clr;
    enter_idle = 1'b0;

    if (conflict) begin
      state_d   = IDLE;
      cnt_d     = '0;
      err_sel_d = 1'b1;
    end else begin
      unique case (state_q)
        SH_DYN: begin
          if (dyn_go) begin
            sr_dyn_d = {sr_dyn_q[SIZESRDYN-2:0], bus.signal_in};
            cnt_d    = cnt_inc;
          end else begin
            if (cnt_q == CW'(SIZESRDYN)) begin
              dyn_cfg_d = sr_dyn_q;
              dyn_upd_d = 1'b1;
            end else begin
              err_len_d = 1'b1;
            end
            enter_idle = 1'b1;
          end
        end
        SH_STAT: begin
          if (stat_go) begin
            sr_stat_d = {sr_stat_q[SIZESRSTAT-2:0], bus.signal_in};
            cnt_d     = cnt_inc;
          end else begin
            if (cnt_q == CW'(SIZESRSTAT)) begin
              stat_cfg_d = sr_stat_q;
              stat_upd_d = 1'b1;
            end else begin
              err_len_d = 1'b1;
            end
            enter_idle = 1'b1;
          end
        end
        default: enter_idle = 1'b1;
      endcase

      // Exit and entry share one edge so back-to-back frames lose no bit.
      if (enter_idle) begin
        if (dyn_go) begin
          state_d  = SH_DYN;
          sr_dyn_d = {sr_dyn_q[SIZESRDYN-2:0], bus.signal_in};
          cnt_d    = CW'(1);
        end else if (stat_go) begin
          state_d   = SH_STAT;
          sr_stat_d = {sr_stat_q[SIZESRSTAT-2:0], bus.signal_in};
          cnt_d     = CW'(1);
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sr_dyn_q   <= '0;
      sr_stat_q  <= '0;
      dyn_cfg_q  <= '0;
      stat_cfg_q <= '0;
      dyn_upd_q  <= 1'b0;
      stat_upd_q <= 1'b0;
      err_len_q  <= 1'b0;
      err_sel_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_dyn_q   <= sr_dyn_d;
      sr_stat_q  <= sr_stat_d;
      dyn_cfg_q  <= dyn_cfg_d;
      stat_cfg_q <= stat_cfg_d;
      dyn_upd_q  <= dyn_upd_d;
      stat_upd_q <= stat_upd_d;
      err_len_q  <= err_len_d;
      err_sel_q  <= err_sel_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.dyn_cfg  = dyn_cfg_q;
  assign bus.stat_cfg = stat_cfg_q;
  assign bus.addr_mux = stat_cfg_q[SIZEADDRMUX-1:0];
  assign bus.dyn_upd  = dyn_upd_q;
  assign bus.stat_upd = stat_upd_q;
  assign bus.err_len  = err_len_q;
  assign bus.err_sel  = err_sel_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_cfg_shift_regs.sv
// Directed bench for cfg_shift_regs: upd pulses are checked against a queue of expected
// committed words, everything else is checked inline after each step.
module tb_cfg_shift_regs;

  localparam int SS = 88;
  localparam int SD = 16;
  localparam int SA = 7;

  logic CLK = 1'b0;
  logic RST_N;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   dyn_upd_cyc = -1;
  int   stat_upd_cyc = -1;

  logic [SS-1:0] dq[$];
  logic [SS-1:0] sq[$];

  cfg_shift_regs_if #(.SIZESRSTAT(SS), .SIZESRDYN(SD), .SIZEADDRMUX(SA)) bus ();

  cfg_shift_regs #(.SIZESRSTAT(SS), .SIZESRDYN(SD), .SIZEADDRMUX(SA)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic chk(input string tag, input logic [SS-1:0] obs, input logic [SS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every upd pulse must match the oldest expected commit.
  always @(negedge CLK) begin
    if (RST_N === 1'b1 && bus.dyn_upd === 1'b1) begin
      dyn_upd_cyc = cyc;
      if (dq.size() == 0) chk("dyn_upd_unexpected", {{(SS-1){1'b0}}, 1'b1}, '0);
      else chk("dyn_cfg_on_upd", {{(SS-SD){1'b0}}, bus.dyn_cfg}, dq.pop_front());
    end
    if (RST_N === 1'b1 && bus.stat_upd === 1'b1) begin
      stat_upd_cyc = cyc;
      if (sq.size() == 0) chk("stat_upd_unexpected", {{(SS-1){1'b0}}, 1'b1}, '0);
      else chk("stat_cfg_on_upd", bus.stat_cfg, sq.pop_front());
    end
  end

  task automatic drive(input logic sd, input logic ss, input logic ef, input logic b);
    bus.sel_dyn   = sd;
    bus.sel_stat  = ss;
    bus.en_fin    = ef;
    bus.signal_in = b;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_dyn(input logic [SS-1:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) drive(1'b1, 1'b0, 1'b0, v[i]);
  endtask

  task automatic send_stat(input logic [SS-1:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) drive(1'b0, 1'b1, 1'b0, v[i]);
  endtask

  logic [SS-1:0] pat1, pat2;
  logic [SD-1:0] exp_dyn;

  initial begin
    pat1 = 88'h0123456789ABCDEF012355;
    pat2 = 88'hF00DCAFE5A5AC3C3BEEF2A;
    RST_N = 1'b0;
    bus.sel_dyn = 0; bus.sel_stat = 0; bus.en_fin = 0; bus.signal_in = 0; bus.err_clr = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_dyn_cfg",  {{(SS-SD){1'b0}}, bus.dyn_cfg}, '0);
    chk("reset_stat_cfg", bus.stat_cfg, '0);
    chk("reset_flags", {bus.busy, bus.err_len, bus.err_sel, bus.dyn_upd, bus.stat_upd}, '0);
    RST_N = 1'b1;

    // Full 16-bit dynamic frame, MSB first.
    exp_dyn = 16'h8001;
    dq.push_back({{(SS-SD){1'b0}}, exp_dyn});
    send_dyn({{(SS-SD){1'b0}}, exp_dyn}, SD);
    chk("busy_during_dyn", {{(SS-1){1'b0}}, bus.busy}, 1);
    drive(0, 0, 0, 0);
    chk("dyn_cfg_8001", {{(SS-SD){1'b0}}, bus.dyn_cfg}, {{(SS-SD){1'b0}}, exp_dyn});
    chk("dyn_upd_pulse", {{(SS-1){1'b0}}, bus.dyn_upd}, 1);
    chk("err_len_clean", {{(SS-1){1'b0}}, bus.err_len}, 0);
    drive(0, 0, 0, 0);
    chk("dyn_upd_one_cycle", {{(SS-1){1'b0}}, bus.dyn_upd}, 0);

    // Dynamic frame handing straight over to a static frame.
    exp_dyn = 16'h3C96;
    dq.push_back({{(SS-SD){1'b0}}, exp_dyn});
    sq.push_back(pat1);
    send_dyn({{(SS-SD){1'b0}}, exp_dyn}, SD);
    send_stat(pat1, SS);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("stat_cfg_pat1", bus.stat_cfg, pat1);
    chk("addr_mux_55", {{(SS-SA){1'b0}}, bus.addr_mux}, {{(SS-SA){1'b0}}, 7'h55});
    chk("upd_spacing", SS'(stat_upd_cyc - dyn_upd_cyc), SS'(SS));
    chk("dyn_cfg_3c96", {{(SS-SD){1'b0}}, bus.dyn_cfg}, {{(SS-SD){1'b0}}, exp_dyn});

    // Short and long frames flag err_len and leave dyn_cfg alone.
    send_dyn(88'h1234, 15);
    drive(0, 0, 0, 0);
    chk("err_len_15", {{(SS-1){1'b0}}, bus.err_len}, 1);
    chk("dyn_keep_15", {{(SS-SD){1'b0}}, bus.dyn_cfg}, {{(SS-SD){1'b0}}, exp_dyn});
    bus.err_clr = 1; drive(0, 0, 0, 0); bus.err_clr = 0;
    chk("err_len_cleared", {{(SS-1){1'b0}}, bus.err_len}, 0);
    send_dyn(88'h1ABCD, 17);
    drive(0, 0, 0, 0);
    chk("err_len_17", {{(SS-1){1'b0}}, bus.err_len}, 1);
    chk("dyn_keep_17", {{(SS-SD){1'b0}}, bus.dyn_cfg}, {{(SS-SD){1'b0}}, exp_dyn});
    bus.err_clr = 1; drive(0, 0, 0, 0); bus.err_clr = 0;

    // Select conflict mid-frame; clear in the same cycle as a set must lose.
    send_dyn(88'h15, 5);
    drive(1, 1, 0, 1);
    chk("err_sel_set", {{(SS-1){1'b0}}, bus.err_sel}, 1);
    chk("conflict_idle", {{(SS-1){1'b0}}, bus.busy}, 0);
    bus.err_clr = 1;
    drive(1, 1, 0, 0);
    chk("err_sel_set_wins", {{(SS-1){1'b0}}, bus.err_sel}, 1);
    drive(0, 0, 0, 0);
    bus.err_clr = 0;
    chk("err_sel_cleared", {{(SS-1){1'b0}}, bus.err_sel}, 0);
    chk("err_len_no_conflict", {{(SS-1){1'b0}}, bus.err_len}, 0);

    // en_fin ends a frame (commit), then a long wait phase must not shift.
    exp_dyn = 16'hA55A;
    dq.push_back({{(SS-SD){1'b0}}, exp_dyn});
    send_dyn({{(SS-SD){1'b0}}, exp_dyn}, SD);
    for (int i = 0; i < 128; i++) drive(1, 0, 1, 1'($urandom_range(1)));
    chk("wait_busy", {{(SS-1){1'b0}}, bus.busy}, 0);
    chk("wait_dyn_stable", {{(SS-SD){1'b0}}, bus.dyn_cfg}, {{(SS-SD){1'b0}}, exp_dyn});
    chk("wait_err_len", {{(SS-1){1'b0}}, bus.err_len}, 0);
    drive(0, 0, 0, 0);

    // Reset 40 bits into a static frame, with err_len left set beforehand.
    send_dyn(88'h3, 3);
    drive(0, 0, 0, 0);
    send_stat(pat2 >> 48, 40);
    #2 RST_N = 1'b0;
    #1;
    chk("async_rst_cfg", bus.stat_cfg | {{(SS-SD){1'b0}}, bus.dyn_cfg}, '0);
    chk("async_rst_flags", {bus.busy, bus.err_len, bus.err_sel, bus.dyn_upd, bus.stat_upd, bus.addr_mux}, '0);
    bus.sel_stat = 0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    sq.push_back(pat2);
    send_stat(pat2, SS);
    drive(0, 0, 0, 0);
    chk("post_rst_stat", bus.stat_cfg, pat2);
    chk("post_rst_addr", {{(SS-SA){1'b0}}, bus.addr_mux}, {{(SS-SA){1'b0}}, pat2[SA-1:0]});
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("dyn_queue_drained", SS'(dq.size()), '0);
    chk("stat_queue_drained", SS'(sq.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
